// File: rtl/matrix_row_packer.sv
// Packs ROWS consecutive ROW_W-bit row beats into one matrix word using two ping-pong banks.
// Define MATRIX_PACKER_LAST_CHK_EN to honour in_last and report framing errors on err_short/err_long.
module matrix_row_packer #(
  parameter int ROW_W = 256,
  parameter int ROWS  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [ROW_W-1:0]        in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ROWS*ROW_W-1:0]   out_matrix,
  output logic                           err_short,
  output logic                           err_long
);

  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MAT_W = ROWS * ROW_W;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  logic [MAT_W-1:0] bank_q [2];
  logic [MAT_W-1:0] bank_d [2];
  logic [1:0]       full_q;
  logic [1:0]       full_d;
  logic             wr_bank_q;
  logic             wr_bank_d;
  logic             rd_bank_q;
  logic             rd_bank_d;
  logic [CNT_W-1:0] row_cnt_q;
  logic [CNT_W-1:0] row_cnt_d;

  logic accept_s;
  logic release_s;
  logic commit_s;
  logic last_row_s;

  assign in_ready   = ~full_q[wr_bank_q];
  assign out_valid  = full_q[rd_bank_q];
  assign out_matrix = bank_q[rd_bank_q];

  assign accept_s   = in_valid & in_ready;
  assign release_s  = out_valid & out_ready;
  assign last_row_s = (row_cnt_q == LAST_ROW);

`ifdef MATRIX_PACKER_LAST_CHK_EN
  logic err_short_q;
  logic err_short_d;
  logic err_long_q;
  logic err_long_d;

  assign commit_s  = accept_s & (last_row_s | in_last);
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

  // Sticky framing-error flags; only reset clears them.
  always_comb begin
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    if (accept_s) begin
      if (in_last && !last_row_s) begin
        err_short_d = 1'b1;
      end else begin
        err_short_d = err_short_q;
      end
      if (!in_last && last_row_s) begin
        err_long_d = 1'b1;
      end else begin
        err_long_d = err_long_q;
      end
    end else begin
      err_short_d = err_short_q;
      err_long_d  = err_long_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end
`else
  logic unused_in_last_s;

  assign unused_in_last_s = in_last;
  assign commit_s         = accept_s & last_row_s;
  assign err_short        = 1'b0;
  assign err_long         = 1'b0;
`endif

  // Row write into the fill bank; the first row of a matrix wipes stale rows so short matrices read zero.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    if (accept_s) begin
      if (row_cnt_q == '0) begin
        bank_d[wr_bank_q] = '0;
      end else begin
        bank_d[wr_bank_q] = bank_q[wr_bank_q];
      end
      for (int k = 0; k < ROWS; k++) begin
        if (row_cnt_q == CNT_W'(k)) begin
          bank_d[wr_bank_q][(ROWS-k)*ROW_W-1 -: ROW_W] = in_data;
        end else begin
          bank_d[wr_bank_q][(ROWS-k)*ROW_W-1 -: ROW_W] = bank_d[wr_bank_q][(ROWS-k)*ROW_W-1 -: ROW_W];
        end
      end
    end else begin
      bank_d[0] = bank_q[0];
      bank_d[1] = bank_q[1];
    end
  end

  // Bank bookkeeping; commit and release never target the same bank, so both may apply together.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    row_cnt_d = row_cnt_q;
    if (commit_s) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
      row_cnt_d         = '0;
    end else if (accept_s) begin
      row_cnt_d = row_cnt_q + CNT_W'(1);
    end else begin
      row_cnt_d = row_cnt_q;
    end
    if (release_s) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end
  end

  // State registers; reset discards any partial or held matrix.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      row_cnt_q <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      row_cnt_q <= row_cnt_d;
    end
  end

endmodule

// File: tb/tb_matrix_row_packer.sv
// Randomised scoreboard bench for matrix_row_packer; the reference model packs rows by queue arithmetic.
module tb_matrix_row_packer;

  localparam int ROW_W = 256;
  localparam int ROWS  = 16;
  localparam int MW    = ROW_W * ROWS;
`ifdef MATRIX_PACKER_LAST_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_last = 1'b0;
  logic                    out_ready = 1'b0;
  logic signed [ROW_W-1:0] in_data = '0;
  logic                    in_ready;
  logic                    out_valid;
  logic signed [MW-1:0]    out_matrix;
  logic                    err_short;
  logic                    err_long;

  logic [MW-1:0]    exp_q [$];
  logic [ROW_W-1:0] part_q [$];
  bit               exp_err_short = 1'b0;
  bit               exp_err_long  = 1'b0;
  int               n_cmp = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  matrix_row_packer #(.ROW_W(ROW_W), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_matrix(out_matrix),
    .err_short(err_short), .err_long(err_long)
  );

  // Rows in arrival order; first row ends up in the MSBs, missing rows are zero at the bottom.
  function automatic logic [MW-1:0] pack_rows();
    logic [MW-1:0] m = '0;
    foreach (part_q[i]) m = (m << ROW_W) | MW'(part_q[i]);
    m = m << ((ROWS - part_q.size()) * ROW_W);
    return m;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_bit(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_mat(string name, logic [MW-1:0] act, logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      for (int r = 0; r < ROWS; r++) begin
        if (act[(ROWS-r)*ROW_W-1 -: ROW_W] !== exp[(ROWS-r)*ROW_W-1 -: ROW_W]) begin
          $display("FAIL %s row %0d: got %h expected %h at %0t", name, r,
                   act[(ROWS-r)*ROW_W-1 -: ROW_W], exp[(ROWS-r)*ROW_W-1 -: ROW_W], $time);
          break;
        end
      end
    end
  endtask

  // Monitor: compare DUT against model state, then advance the model by this cycle's handshakes.
  always @(negedge clk) begin : monitor
    bit ready_m;
    if (rst) begin
      exp_q.delete();
      part_q.delete();
      exp_err_short = 1'b0;
      exp_err_long  = 1'b0;
    end else begin
      ready_m = (exp_q.size() < 2);
      chk_bit("in_ready", in_ready, ready_m);
      chk_bit("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) chk_mat("out_matrix", out_matrix, exp_q[0]);
      chk_bit("err_short", err_short, exp_err_short);
      chk_bit("err_long", err_long, exp_err_long);
      if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && ready_m) begin
        if (CHK && in_last && part_q.size() < ROWS - 1) exp_err_short = 1'b1;
        if (CHK && !in_last && part_q.size() == ROWS - 1) exp_err_long = 1'b1;
        part_q.push_back(in_data);
        if (part_q.size() == ROWS || (CHK && in_last)) begin
          exp_q.push_back(pack_rows());
          part_q.delete();
        end
      end
    end
  end

  task automatic send_row(logic [ROW_W-1:0] data, logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready still 0 after %0d cycles, required 1", waited);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit done;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Sixteen back-to-back beats carrying their own index.
    out_ready = 1'b1;
    for (int i = 0; i < ROWS; i++) send_row(ROW_W'(i), i == ROWS - 1);
    idle(3);

    // Fill both banks with the consumer stalled, then release one matrix for a single cycle.
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 3 * ROWS; i++) send_row(rand_row(), (i % ROWS) == ROWS - 1);
      begin
        idle(40);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        idle(25);
        out_ready = 1'b1;
      end
    join
    idle(4);

    // Commit of the second bank on the very cycle the first bank is released.
    out_ready = 1'b0;
    for (int i = 0; i < 2 * ROWS - 1; i++) send_row(rand_row(), (i % ROWS) == ROWS - 1);
    out_ready = 1'b1;
    send_row(rand_row(), 1'b1);
    out_ready = 1'b0;
    idle(2);
    out_ready = 1'b1;
    idle(4);

    // Random traffic with random gaps, stray in_last and a random consumer.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send_row(rand_row(), ($urandom_range(0, 9) == 0) || ((i % ROWS) == ROWS - 1));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        done = 1'b1;
      end
      while (!done) begin
        out_ready = ($urandom_range(0, 2) != 0);
        idle(1);
      end
    join
    out_ready = 1'b1;
    idle(4);

    // Short matrix of 0xFF rows terminated by in_last, then a well-formed one.
    do_reset();
    for (int i = 0; i < 5; i++) send_row({(ROW_W/8){8'hFF}}, i == 4);
    for (int i = 0; i < ROWS; i++) send_row(rand_row(), i == ROWS - 1);
    idle(4);

    // Reset while holding one matrix and partway through another, then a clean 0xA5 matrix.
    out_ready = 1'b0;
    for (int i = 0; i < ROWS + 7; i++) send_row(rand_row(), (i % ROWS) == ROWS - 1);
    do_reset();
    idle(2);
    out_ready = 1'b1;
    for (int i = 0; i < ROWS; i++) send_row({(ROW_W/8){8'hA5}}, i == ROWS - 1);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_row_packer.md
# matrix_row_packer

Upstream feeder for the 1x64 PE matrix-row splitter. Accepts a stream of 256-bit rows over a valid/ready handshake, packs 16 consecutive rows into one 4096-bit matrix word, and presents it with an `out_valid`/`out_ready` handshake. The splitter's `en` is driven from `out_valid & out_ready`. Two ping-pong banks let row N+1 load while matrix N waits for the consumer, sustaining one matrix per 16 cycles.

## Interface
- `ROW_W`, 256, width of one row beat in bits
- `ROWS`, 16, rows per matrix; `out_matrix` width = ROWS*ROW_W
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  row beat valid
- `in_ready`  out  1  packer can accept a beat
- `in_data`  in  ROW_W  row payload, signed
- `in_last`  in  1  final row of a matrix; used only with MATRIX_PACKER_LAST_CHK_EN
- `out_valid`  out  1  complete matrix available
- `out_ready`  in  1  consumer takes the matrix this cycle
- `out_matrix`  out  ROWS*ROW_W  packed matrix, signed
- `err_short`  out  1  sticky; `in_last` arrived before row ROWS-1
- `err_long`  out  1  sticky; row ROWS-1 arrived without `in_last`

## Operation
- State: two banks `bank[0..1]` (ROWS*ROW_W each), `full[1:0]`, `wr_bank`, `rd_bank`, and a row counter `row_cnt` (0..ROWS-1, log2(ROWS) bits).
- Accept = `in_valid & in_ready`, with `in_ready = ~full[wr_bank]`.
- Packing order: the row accepted at `row_cnt = k` is written to slice `[(ROWS-k)*ROW_W-1 -: ROW_W]`. The first row lands in the MSBs and becomes the splitter's Matrix_0.
- On an accept with `row_cnt == 0`, the other slices of `bank[wr_bank]` clear to 0 in the same cycle. Unwritten rows therefore always read as zero.
- Commit happens on an accept with `row_cnt == ROWS-1`, or on an accept with `in_last` when the check is enabled. On commit:
  - `full[wr_bank]` is set and `wr_bank` toggles.
  - `row_cnt` returns to 0.
- `out_valid = full[rd_bank]` and `out_matrix = bank[rd_bank]`, both combinational from registers.
- Release = `out_valid & out_ready`. On release `full[rd_bank]` clears and `rd_bank` toggles. Bank contents are retained until overwritten.
- A commit and a release in the same cycle act on different banks, and both take effect.
- When both banks are full, `in_ready` is 0 and `row_cnt` holds.
- Reset values:
  - banks, `full`, `wr_bank`, `rd_bank`, `row_cnt` = 0
  - `out_valid` = 0, `out_matrix` = 0
  - `err_short` = 0, `err_long` = 0
  - `in_ready` = 1 from the first cycle after reset.
- A reset during a partial fill or while holding a matrix discards all data. No matrix is emitted afterwards.

## Timing
- Latency: last row accepted at edge N → `out_valid` = 1 after edge N. The splitter samples it at edge N+1.
- `in_ready` falls on the cycle after the commit that fills the second bank. It rises on the cycle after a release.
- `out_matrix` is stable while `out_valid` = 1 and `out_ready` = 0.
- Sustained throughput: 1 row/cycle and 1 matrix per ROWS cycles, provided `out_ready` is asserted at least once per ROWS cycles.

## Configuration
- `MATRIX_PACKER_LAST_CHK_EN` defined:
  - `in_last` on an accept with `row_cnt < ROWS-1` commits early with the remaining rows zero, and sets `err_short`.
  - An accept at `row_cnt == ROWS-1` without `in_last` commits normally and sets `err_long`.
  - Both flags clear only on `rst`.
- Not defined:
  - `in_last` is ignored and commit occurs only at `row_cnt == ROWS-1`.
  - `err_short` and `err_long` are tied to 0.

## Test plan
- Reset, then 16 back-to-back beats with `in_data` = row index (0..15) and `out_ready` = 1:
  - `out_valid` pulses 1 cycle after beat 15.
  - `out_matrix[4095:3840]` = 0 and `out_matrix[255:0]` = 15.
- Stream 48 rows with `out_ready` = 0:
  - `in_ready` drops after row 31 and rows 32+ stall.
  - Raising `out_ready` for 1 cycle releases matrix 0. `in_ready` returns the next cycle and matrix 1 is then presented unchanged.
- Commit and release in the same cycle:
  - Bank 1 completes on the exact cycle bank 0 is released.
  - `out_valid` stays 1, `out_matrix` switches to bank 1, and no beat is lost.
- With `MATRIX_PACKER_LAST_CHK_EN`, send 5 rows of 0xFF with `in_last` on row 4:
  - Commit occurs after row 4, rows 5..15 read 0, and `err_short` = 1.
  - The next 16-row matrix with `in_last` on row 15 is clean and `err_short` stays 1.
- Assert `rst` after 7 accepted rows:
  - `out_valid` = 0, `in_ready` = 1, and `row_cnt` = 0.
  - Then 16 rows of 0xA5 produce a matrix of all 0xA5 with no residue from the 7 earlier rows.
